aes64_round_ctrl: RTL and testbench

//  Iterative round controller for the 64-bit (2x4-byte state) AES-style cipher.
//  - Accepts one plaintext block and sequences ROUNDS rounds over a single shared round datapath.
//  - The round datapath is SubBytes -> ShiftRows -> mix_coloumns -> AddRoundKey.
//  - Round keys come from an external key store.
//  - Sits between the host-side block interface and the key-schedule RAM. Encrypt only.

---
 rtl/aes64_pkg.sv | 44 ++++
 rtl/aes64_round.sv | 32 +++
 rtl/mix_coloumns.sv | 18 +
 rtl/aes64_round_ctrl.sv | 131 +++++++++++++
 tb/tb_aes64_round_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes64_pkg.sv
// Shared types, constants and GF(2^8) helpers for the 64-bit AES-style round controller.
// Block byte k sits at bits [8k+7:8k]; bytes 0..3 form row 0 and bytes 4..7 form row 1.
package aes64_pkg;

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NBYTES = BLK_W / BYTE_W;
  localparam int unsigned COLS   = NBYTES / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [BYTE_W-1:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_W-1:0] gf_xtime(input logic [BYTE_W-1:0] b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] get_byte(input logic [BLK_W-1:0] w, input int unsigned k);
    return w[BYTE_W*k +: BYTE_W];
  endfunction

endpackage

// File: rtl/aes64_round.sv
// One combinational cipher round: SubBytes -> ShiftRows -> (mix, skipped on last) -> AddRoundKey.
module aes64_round
  import aes64_pkg::*;
(
  input  logic [BLK_W-1:0] i_st,
  input  logic [BLK_W-1:0] i_rk,
  input  logic             i_last,
  output logic [BLK_W-1:0] o_st_c
);

  logic [BLK_W-1:0] w_sb;
  logic [BLK_W-1:0] w_sr;
  logic [BLK_W-1:0] w_mc;

  for (genvar g = 0; g < NBYTES; g++) begin : g_sb
    assign w_sb[BYTE_W*g +: BYTE_W] = SBOX[get_byte(i_st, g)];
  end

  // Row 0 passes through; row 1 rotates left by one byte.
  for (genvar g = 0; g < COLS; g++) begin : g_sr
    assign w_sr[BYTE_W*g +: BYTE_W]        = get_byte(w_sb, g);
    assign w_sr[BYTE_W*(COLS+g) +: BYTE_W] = get_byte(w_sb, COLS + ((g + 1) % COLS));
  end

  mix_coloumns u_mc (
    .i_data   (w_sr),
    .o_data_c (w_mc)
  );

  assign o_st_c = (i_last ? w_sr : w_mc) ^ i_rk;

endmodule

// File: rtl/mix_coloumns.sv
// Column mixer for the two-row state: out[i] = 2a ^ 3b, out[i+4] = a ^ b, a = in[i], b = in[i+4].
module mix_coloumns
  import aes64_pkg::*;
(
  input  logic [BLK_W-1:0] i_data,
  output logic [BLK_W-1:0] o_data_c
);

  for (genvar g = 0; g < COLS; g++) begin : g_col
    logic [BYTE_W-1:0] w_a;
    logic [BYTE_W-1:0] w_b;
    assign w_a = get_byte(i_data, g);
    assign w_b = get_byte(i_data, COLS + g);
    assign o_data_c[BYTE_W*g +: BYTE_W]          = gf_xtime(w_a) ^ gf_xtime(w_b) ^ w_b;
    assign o_data_c[BYTE_W*(COLS+g) +: BYTE_W]   = w_a ^ w_b;
  end

endmodule

// File: rtl/aes64_round_ctrl.sv
// Iterative encrypt-only round controller: accepts one block, runs ROUNDS rounds on a shared
// datapath using keys fetched from an external store, then holds the ciphertext until taken.
module aes64_round_ctrl
  import aes64_pkg::*;
#(
  parameter  int unsigned ROUNDS = 6,
  localparam int unsigned RCW    = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic [RCW-1:0]   rk_idx,
  input  logic [BLK_W-1:0] rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [RCW-1:0]   r_rc;
  logic [RCW-1:0]   w_rc_nxt;
  logic [BLK_W-1:0] r_st;
  logic [BLK_W-1:0] w_st_nxt;
  logic [BLK_W-1:0] w_round_c;
  logic             w_last;
  logic             w_accept;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;
  logic             w_busy_nxt;

  assign w_last   = (r_rc == RCW'(ROUNDS));
  assign w_accept = in_valid & r_in_ready;

  aes64_round u_round (
    .i_st   (r_st),
    .i_rk   (rk_data),
    .i_last (w_last),
    .o_st_c (w_round_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, round counter and cipher state; flush overrides every transition but keeps st.
  always_comb begin
    w_state_nxt = r_state;
    w_rc_nxt    = r_rc;
    w_st_nxt    = r_st;
    if (flush) begin
      w_state_nxt = IDLE;
      w_rc_nxt    = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_st_nxt    = in_data ^ rk_data;
            w_rc_nxt    = RCW'(1);
            w_state_nxt = ROUND;
          end
        end
        ROUND: begin
          w_st_nxt = w_round_c;
          if (w_last) begin
            w_state_nxt = DONE;
          end else begin
            w_rc_nxt = RCW'(r_rc + RCW'(1));
          end
        end
        DONE: begin
          if (out_ready) begin
            w_state_nxt = IDLE;
            w_rc_nxt    = '0;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_rc_nxt    = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    case (w_state_nxt)
      IDLE:    w_in_ready_nxt  = 1'b1;
      ROUND:   w_busy_nxt      = 1'b1;
      DONE:    w_out_valid_nxt = 1'b1;
      default: w_in_ready_nxt  = 1'b0;
    endcase
  end

  // Status flags are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rc        <= '0;
      r_st        <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rc        <= w_rc_nxt;
      r_st        <= w_st_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign rk_idx    = r_rc;
  assign out_data  = r_st;

endmodule

// File: tb/tb_aes64_round_ctrl.sv
// Randomized self-checking bench for aes64_round_ctrl against a byte-array cipher model
// whose S-box is derived from the GF(2^8) inverse and affine map.
module tb_aes64_round_ctrl;

  localparam int unsigned TB_ROUNDS = 2;
  localparam int unsigned RCW       = $clog2(TB_ROUNDS + 1);

  typedef logic [63:0] key_arr_t [0:3];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0]    in_data, rk_data, out_data;
  logic [RCW-1:0] rk_idx;
  key_arr_t       rk_mem;
  assign rk_data = rk_mem[rk_idx];

  logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [63:0] in_data1, rk_data1, out_data1;
  logic [0:0]  rk_idx1;
  logic [63:0] rk_mem1 [0:1];
  assign rk_data1 = rk_mem1[rk_idx1];

  aes64_round_ctrl #(.ROUNDS(TB_ROUNDS)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rk_idx(rk_idx), .rk_data(rk_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  aes64_round_ctrl #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .rk_idx(rk_idx1), .rk_data(rk_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .busy(busy1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_tab [0:255];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? (8'({x[6:0], 1'b0}) ^ 8'h1b) : 8'({x[6:0], 1'b0});
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Cipher state after 'upto' rounds of an nr-round encryption.
  function automatic logic [63:0] ref_state(input logic [63:0] pt, input key_arr_t keys,
                                            input int nr, input int upto);
    logic [7:0]  s [8];
    logic [7:0]  u [8];
    logic [7:0]  v [8];
    logic [63:0] res;
    for (int k = 0; k < 8; k++) s[k] = pt[8*k +: 8] ^ keys[0][8*k +: 8];
    for (int r = 1; r <= upto; r++) begin
      for (int k = 0; k < 8; k++) u[k] = sb_tab[s[k]];
      for (int i = 0; i < 4; i++) begin
        v[i]     = u[i];
        v[4 + i] = u[4 + ((i + 1) % 4)];
      end
      for (int i = 0; i < 4; i++) begin
        if (r < nr) begin
          u[i]     = gmul(v[i], 8'h02) ^ gmul(v[i + 4], 8'h03);
          u[i + 4] = v[i] ^ v[i + 4];
        end else begin
          u[i]     = v[i];
          u[i + 4] = v[i + 4];
        end
      end
      for (int k = 0; k < 8; k++) s[k] = u[k] ^ keys[r][8*k +: 8];
    end
    for (int k = 0; k < 8; k++) res[8*k +: 8] = s[k];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_keys();
    for (int i = 0; i < 4; i++) rk_mem[i] = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input string tag);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check_eq({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
  endtask

  // Encrypt one block with random side-traffic during the rounds, then hold it 'hold' cycles.
  task automatic run_block(input logic [63:0] pt, input int hold, input string tag,
                           output logic [63:0] got_r1, output logic [63:0] got);
    logic [63:0] exp;
    int          lat;
    wait_idle(tag);
    exp       = ref_state(pt, rk_mem, TB_ROUNDS, TB_ROUNDS);
    in_data   = pt;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    lat    = 1;
    got_r1 = '0;
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    check_eq({tag, "_rdy_lo"}, 64'(in_ready), 64'd0);
    while (!out_valid && lat < 50) begin
      check_eq({tag, "_rkidx"}, 64'(rk_idx), 64'(lat));
      in_valid  = 1'($urandom % 2);
      in_data   = {$urandom, $urandom};
      out_ready = 1'($urandom % 2);
      tick();
      lat++;
      if (lat == 2) got_r1 = out_data;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    got       = out_data;
    check_eq({tag, "_lat"}, 64'(lat), 64'(TB_ROUNDS + 1));
    check_eq({tag, "_data"}, out_data, exp);
    check_eq({tag, "_busy_lo"}, 64'(busy), 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom % 2);
      in_data  = {$urandom, $urandom};
      tick();
      check_eq({tag, "_hold_v"}, 64'(out_valid), 64'd1);
      check_eq({tag, "_hold_d"}, out_data, exp);
      check_eq({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_taken_v"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_taken_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] pt, r1, got, mid;
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    for (int i = 0; i < 4; i++) rk_mem[i] = '0;
    rk_mem1[0] = '0;
    rk_mem1[1] = '0;
    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rk_idx", 64'(rk_idx), 64'd0);
    check_eq("rst_out_data", out_data, 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_in_ready", 64'(in_ready), 64'd1);
    check_eq("idle1_in_ready", 64'(in_ready1), 64'd1);

    // ROUNDS=1: single final round, no mix.
    in_data1  = '0;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check_eq("r1_busy", 64'(busy1), 64'd1);
    check_eq("r1_early_v", 64'(out_valid1), 64'd0);
    tick();
    check_eq("r1_valid", 64'(out_valid1), 64'd1);
    check_eq("r1_data", out_data1, 64'h6363636363636363);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check_eq("r1_taken", 64'(out_valid1), 64'd0);
    check_eq("r1_rdy", 64'(in_ready1), 64'd1);

    // out_ready in IDLE has no effect.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("idle_ordy_rdy", 64'(in_ready), 64'd1);
    check_eq("idle_ordy_v", 64'(out_valid), 64'd0);

    run_block(64'd0, 0, "zero", r1, got);
    check_eq("zero_r1", r1, 64'h0000000063636363);
    check_eq("zero_ct", got, 64'h63636363FBFBFBFB);

    for (int i = 0; i < 4; i++) rk_mem[i] = '1;
    run_block('1, 0, "ones", r1, got);

    rand_keys();
    run_block({$urandom, $urandom}, 10, "bp", r1, got);

    // Flush in the second ROUND cycle; st must survive, then a flush beats in_valid in IDLE.
    rand_keys();
    wait_idle("fl");
    pt       = {$urandom, $urandom};
    mid      = ref_state(pt, rk_mem, TB_ROUNDS, 1);
    in_data  = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fl_busy", 64'(busy), 64'd0);
    check_eq("fl_valid", 64'(out_valid), 64'd0);
    check_eq("fl_rdy", 64'(in_ready), 64'd1);
    check_eq("fl_rkidx", 64'(rk_idx), 64'd0);
    check_eq("fl_st_kept", out_data, mid);
    tick();
    check_eq("fl_valid2", 64'(out_valid), 64'd0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flidle_busy", 64'(busy), 64'd0);
    check_eq("flidle_rdy", 64'(in_ready), 64'd1);
    check_eq("flidle_st", out_data, mid);
    rand_keys();
    run_block({$urandom, $urandom}, 1, "postfl", r1, got);

    // Asynchronous reset in the middle of a block.
    rand_keys();
    wait_idle("ar");
    in_data  = {$urandom, $urandom};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_in_ready", 64'(in_ready), 64'd0);
    check_eq("ar_out_valid", 64'(out_valid), 64'd0);
    check_eq("ar_busy", 64'(busy), 64'd0);
    check_eq("ar_rk_idx", 64'(rk_idx), 64'd0);
    check_eq("ar_out_data", out_data, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("ar_rel_rdy", 64'(in_ready), 64'd1);
    rand_keys();
    run_block({$urandom, $urandom}, 0, "postar", r1, got);

    for (int n = 0; n < 20; n++) begin
      rand_keys();
      run_block({$urandom, $urandom}, int'($urandom_range(0, 3)), "rnd", r1, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
